// File: rtl/serial_chunk_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : serial_chunk_adder
// Description : Multi-cycle adder/subtractor. Consumes a WIDTH-bit operand
//               pair CHUNK bits per clock, LSB chunk first, with the carry
//               rippling between cycles through a flip-flop. Reports carry-out
//               and signed overflow. Uses a start/busy/done handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_chunk_adder #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             overflow
);

    // Reject illegal parameter combinations at elaboration time.
    if (WIDTH < 2 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
        $error("serial_chunk_adder: illegal WIDTH/CHUNK combination");
    end

    localparam int c_nchunk = WIDTH / CHUNK;
    localparam int c_cnt_w  = (c_nchunk > 1) ? $clog2(c_nchunk) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(c_nchunk - 1);

    localparam logic [1:0] c_st_idle = 2'd0;
    localparam logic [1:0] c_st_run  = 2'd1;
    localparam logic [1:0] c_st_done = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_opa;
    logic [WIDTH-1:0]   r_opb;
    logic [WIDTH-1:0]   r_res;
    logic               r_carry;
    logic [c_cnt_w-1:0] r_cnt;

    logic [CHUNK:0]     w_chunk;
    logic               w_msb_cin;
    logic [WIDTH-1:0]   w_res_next;

    // One chunk of addition; the top bit is the carry into the next chunk.
    assign w_chunk = {1'b0, r_opa[CHUNK-1:0]} + {1'b0, r_opb[CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, r_carry};

    // Carry into the top bit of this chunk, recovered from that bit's sum.
    assign w_msb_cin = w_chunk[CHUNK-1] ^ r_opa[CHUNK-1] ^ r_opb[CHUNK-1];

    // New chunk enters the result register from the top.
    if (CHUNK == WIDTH) begin : g_res_full
        assign w_res_next = w_chunk[CHUNK-1:0];
    end else begin : g_res_shift
        assign w_res_next = {w_chunk[CHUNK-1:0], r_res[WIDTH-1:CHUNK]};
    end

    // Control FSM plus datapath registers and registered result outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_st_idle;
            r_opa    <= '0;
            r_opb    <= '0;
            r_res    <= '0;
            r_carry  <= 1'b0;
            r_cnt    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            sum      <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                c_st_idle: begin
                    if (start) begin
                        r_opa   <= a;
                        r_opb   <= sub ? ~b : b;
                        r_carry <= sub | cin;
                        r_cnt   <= c_cnt_last;
                        busy    <= 1'b1;
                        r_state <= c_st_run;
                    end
                end
                c_st_run: begin
                    r_res   <= w_res_next;
                    r_opa   <= r_opa >> CHUNK;
                    r_opb   <= r_opb >> CHUNK;
                    r_carry <= w_chunk[CHUNK];
                    if (r_cnt == '0) begin
                        sum      <= w_res_next;
                        cout     <= w_chunk[CHUNK];
                        overflow <= w_msb_cin ^ w_chunk[CHUNK];
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        r_state  <= c_st_done;
                    end else begin
                        r_cnt <= r_cnt - c_cnt_w'(1);
                    end
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_chunk_adder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module      : tb_serial_chunk_adder
// Description : Self-checking bench for serial_chunk_adder. Five instances
//               (WIDTH=8 with CHUNK 1/2/4/8, WIDTH=16 with CHUNK 4) share
//               stimulus and are compared against an arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_chunk_adder;
    localparam int NI = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sub = 1'b0;
    logic        cin = 1'b0;
    logic [15:0] a = '0;
    logic [15:0] b = '0;

    logic [NI-1:0] busy_v, done_v, cout_v, ov_v;
    logic [7:0]    s0, s1, s2, s3;
    logic [15:0]   s4;

    int checks = 0;
    int errors = 0;
    logic [15:0] prev [NI];
    logic [15:0] cap_sum;
    logic        cap_cout, cap_ov;

    always #5 clk = ~clk;

    serial_chunk_adder #(.WIDTH(8), .CHUNK(8)) u_c8 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(busy_v[0]), .done(done_v[0]), .sum(s0), .cout(cout_v[0]), .overflow(ov_v[0]));
    serial_chunk_adder #(.WIDTH(8), .CHUNK(2)) u_c2 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(busy_v[1]), .done(done_v[1]), .sum(s1), .cout(cout_v[1]), .overflow(ov_v[1]));
    serial_chunk_adder #(.WIDTH(8), .CHUNK(4)) u_c4 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(busy_v[2]), .done(done_v[2]), .sum(s2), .cout(cout_v[2]), .overflow(ov_v[2]));
    serial_chunk_adder #(.WIDTH(8), .CHUNK(1)) u_c1 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a[7:0]), .b(b[7:0]), .cin(cin),
        .busy(busy_v[3]), .done(done_v[3]), .sum(s3), .cout(cout_v[3]), .overflow(ov_v[3]));
    serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_w16 (
        .clk(clk), .rst(rst), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy_v[4]), .done(done_v[4]), .sum(s4), .cout(cout_v[4]), .overflow(ov_v[4]));

    function automatic int wid(input int i);
        return (i == 4) ? 16 : 8;
    endfunction

    function automatic int nchunks(input int i);
        case (i)
            0:       return 1;
            1:       return 4;
            2:       return 2;
            3:       return 8;
            default: return 4;
        endcase
    endfunction

    function automatic logic [15:0] get_sum(input int i);
        case (i)
            0:       return {8'h00, s0};
            1:       return {8'h00, s1};
            2:       return {8'h00, s2};
            3:       return {8'h00, s3};
            default: return s4;
        endcase
    endfunction

    // Plain signed/unsigned arithmetic reference.
    function automatic void model(input int w, input logic [15:0] ta, input logic [15:0] tbv,
                                  input logic ts, input logic tc,
                                  output logic [15:0] rs, output logic rc, output logic ro);
        longint md, half, ua, ub, sa, sb, ures, sres;
        md   = longint'(1) << w;
        half = md / 2;
        ua   = longint'(ta) % md;
        ub   = longint'(tbv) % md;
        sa   = (ua >= half) ? ua - md : ua;
        sb   = (ub >= half) ? ub - md : ub;
        if (ts) begin
            ures = ua - ub;
            sres = sa - sb;
            rc   = (ua >= ub);
        end else begin
            ures = ua + ub + longint'(tc);
            sres = sa + sb + longint'(tc);
            rc   = (ures >= md);
        end
        rs = 16'(ures & (md - 1));
        ro = (sres >= half) || (sres < -half);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Launch one operation on all instances and check timing and results.
    task automatic do_op(input logic [15:0] ta, input logic [15:0] tbv,
                         input logic ts, input logic tc, input bit restart);
        int          bcnt [NI];
        int          dcnt [NI];
        int          dcyc [NI];
        bit          ovl [NI];
        bit          held_bad [NI];
        logic [15:0] gs [NI];
        logic        gc [NI];
        logic        go [NI];
        logic [15:0] es;
        logic        ec, eo;
        bit          alldone;
        for (int i = 0; i < NI; i++) begin
            bcnt[i] = 0; dcnt[i] = 0; dcyc[i] = 0; ovl[i] = 0; held_bad[i] = 0;
            gs[i] = '0; gc[i] = 1'b0; go[i] = 1'b0;
        end
        @(negedge clk);
        a = ta; b = tbv; sub = ts; cin = tc; start = 1'b1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(negedge clk);
            if (cyc == 1) begin
                start = 1'b0;
                a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom); cin = 1'($urandom);
            end
            if (restart && cyc == 2) start = 1'b1;
            if (restart && cyc == 3) start = 1'b0;
            alldone = 1'b1;
            for (int i = 0; i < NI; i++) begin
                if (busy_v[i]) begin
                    bcnt[i]++;
                    if (get_sum(i) !== prev[i]) held_bad[i] = 1'b1;
                end
                if (busy_v[i] && done_v[i]) ovl[i] = 1'b1;
                if (done_v[i]) begin
                    dcnt[i]++;
                    dcyc[i] = cyc;
                    gs[i] = get_sum(i); gc[i] = cout_v[i]; go[i] = ov_v[i];
                end
                if (dcnt[i] == 0) alldone = 1'b0;
            end
            if (alldone) break;
        end
        for (int i = 0; i < NI; i++) begin
            model(wid(i), ta, tbv, ts, tc, es, ec, eo);
            chk($sformatf("busy_cycles[%0d]", i), bcnt[i], nchunks(i));
            chk($sformatf("done_count[%0d]", i), dcnt[i], 1);
            chk($sformatf("done_latency[%0d]", i), dcyc[i], nchunks(i) + 1);
            chk($sformatf("busy_done_overlap[%0d]", i), 32'(ovl[i]), 0);
            chk($sformatf("sum_held_in_run[%0d]", i), 32'(held_bad[i]), 0);
            chk($sformatf("sum[%0d]", i), gs[i], es);
            chk($sformatf("cout[%0d]", i), gc[i], ec);
            chk($sformatf("overflow[%0d]", i), go[i], eo);
            if (dcnt[i] > 0) prev[i] = gs[i];
        end
        cap_sum = gs[1]; cap_cout = gc[1]; cap_ov = go[1];
    endtask

    task automatic chk_u2(input string tag, input logic [15:0] es, input logic ec, input logic eo);
        chk({tag, "_sum"}, cap_sum, es);
        chk({tag, "_cout"}, cap_cout, ec);
        chk({tag, "_ovf"}, cap_ov, eo);
    endtask

    initial begin
        bit got_done;
        for (int i = 0; i < NI; i++) prev[i] = '0;

        // Reset state
        repeat (3) @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("reset_sum[%0d]", i), get_sum(i), 0);
            chk($sformatf("reset_flags[%0d]", i),
                {busy_v[i], done_v[i], cout_v[i], ov_v[i]}, 0);
        end
        rst = 1'b0;

        // Directed arithmetic, checked on the WIDTH=8/CHUNK=2 instance
        do_op(16'h005A, 16'h003C, 1'b0, 1'b0, 1'b0);
        chk_u2("add_5a_3c", 16'h0096, 1'b0, 1'b1);
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, 1'b0);
        chk_u2("add_wrap", 16'h0000, 1'b1, 1'b0);
        do_op(16'h00FF, 16'h0001, 1'b0, 1'b1, 1'b0);
        chk_u2("add_wrap_cin", 16'h0001, 1'b1, 1'b0);
        do_op(16'h0010, 16'h0020, 1'b1, 1'b1, 1'b0);
        chk_u2("sub_borrow", 16'h00F0, 1'b0, 1'b0);
        do_op(16'h0080, 16'h0001, 1'b1, 1'b0, 1'b0);
        chk_u2("sub_ovf", 16'h007F, 1'b1, 1'b1);

        // Start pulsed during RUN is ignored
        do_op(16'h0033, 16'h0044, 1'b0, 1'b1, 1'b1);
        chk_u2("restart_ignored", 16'h0078, 1'b0, 1'b0);
        // Next start lands in the IDLE cycle right after the slowest DONE
        do_op(16'h0012, 16'h0034, 1'b0, 1'b0, 1'b0);
        chk_u2("back_to_back", 16'h0046, 1'b0, 1'b0);

        // Reset in the second RUN cycle
        @(negedge clk);
        a = 16'hA5C3; b = 16'h1234; sub = 1'b0; cin = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("midrst_sum[%0d]", i), get_sum(i), 0);
            chk($sformatf("midrst_flags[%0d]", i),
                {busy_v[i], done_v[i], cout_v[i], ov_v[i]}, 0);
            prev[i] = '0;
        end
        got_done = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (|done_v || |busy_v) got_done = 1'b1;
        end
        chk("midrst_no_activity", 32'(got_done), 0);
        do_op(16'h1357, 16'h2468, 1'b1, 1'b0, 1'b0);
        chk_u2("after_midrst", 16'h00EF, 1'b0, 1'b0);

        // Random sweep
        for (int n = 0; n < 1000; n++) begin
            do_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
